// File: rtl/syn_fifo_v2.sv
// Single-clock FIFO with any depth >= 2, programmable almost flags, sticky-free error pulses,
// and either a registered read port or a first-word-fall-through read port.
module syn_fifo_v2 #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 128,
   parameter int AFULL_TH   = DEPTH - 2,
   parameter int AEMPTY_TH  = 2,
   parameter int FWFT       = 0
) (
   input  logic                         sys_clk,
   input  logic                         sys_rst,
   input  logic                         wr_en,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   input  logic                         rd_en,
   output logic [DATA_WIDTH-1:0]        rd_data,
   output logic                         rd_valid,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]   data_count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AFULL_TH);
   localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AEMPTY_TH);

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_acc, rd_acc;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Explicit wrap so non-power-of-two depths never address past the array.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      full         = (count_q == CNT_FULL);
      empty        = (count_q == '0);
      almost_full  = (count_q >= AF_LVL);
      almost_empty = (count_q <= AE_LVL);
      wr_acc       = wr_en && !full;
      rd_acc       = rd_en && !empty;
      wr_ptr_d     = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d     = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d      = count_q;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      overflow_d   = wr_en && full;
      underflow_d  = rd_en && empty;
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is intentionally left out of reset; the count alone defines what is valid.
   always_ff @(posedge sys_clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
   end

   assign data_count = count_q;
   assign overflow   = overflow_q;
   assign underflow  = underflow_q;

   if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; zero while empty so stale storage never leaks out.
      always_comb begin
         rd_valid = !empty;
         rd_data  = empty ? '0 : mem_q[rd_ptr_q];
      end
   end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
      logic                  rd_valid_q, rd_valid_d;

      always_comb begin
         rd_valid_d = rd_acc;
         rd_data_d  = rd_data_q;
         if (rd_acc) rd_data_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge sys_clk or negedge sys_rst) begin
         if (!sys_rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
         end
      end

      always_comb begin
         rd_data  = rd_data_q;
         rd_valid = rd_valid_q;
      end
   end

endmodule
